tv80_bus_model: RTL and testbench
=================================

Name: tv80_bus_model

Overview:
- Parametrised, clocked memory and I/O target for the tv80s bus.
- Successor to the plain testbench memory/IO arrays: adds configurable address widths, programmable wait-state injection per access type, a backdoor preload/peek port, and a write-trace FIFO the bench drains to check bus writes in order.
- Sits between the tv80s core and the bench; drives the CPU `di` and `wait_n` inputs.

Parameters:
- AW, 16, memory address width; memory has 2^AW bytes.
- IO_AW, 8, I/O address width; the low IO_AW bits of `a` select a port.
- MEM_WAIT, 0, wait cycles inserted per memory read/write (0..15).
- IO_WAIT, 1, wait cycles inserted per I/O read/write (0..15).
- LOG_DEPTH, 16, trace FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- a  in  AW  CPU address bus.
- cpu_do  in  8  CPU data out.
- di  out  8  data to CPU.
- mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  CPU strobes.
- wait_n  out  1  wait request to CPU.
- bd_we  in  1  backdoor write strobe.
- bd_io  in  1  backdoor selects the I/O array when 1.
- bd_addr  in  AW  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  backdoor read data, registered, 1-cycle latency.
- log_valid  out  1  trace FIFO not empty.
- log_ready  in  1  bench pops the head entry.
- log_data  out  AW+9  head entry: {is_io, addr[AW-1:0], data[7:0]}.
- log_count  out  $clog2(LOG_DEPTH)+1  FIFO occupancy.
- log_overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - wait_n = 1, di = 00, bd_rdata = 00.
  - log_valid = 0, log_count = 0, log_overflow = 0.
  - FSM = IDLE.
  - Array contents are NOT cleared by reset.
- Access decode:
  - mem_acc = !mreq_n & rfsh_n & (!rd_n | !wr_n).
  - io_acc = !iorq_n & m1_n & (!rd_n | !wr_n). Interrupt acknowledge and refresh are ignored.
- Read path:
  - di is registered every clk.
  - di = io[a[IO_AW-1:0]] when !iorq_n, else mem[a].
- Write:
  - Performed once per access, in the cycle the FSM leaves IDLE (start cycle) with wr_n = 0.
  - The same cycle pushes {is_io, a, cpu_do} into the trace FIFO.
  - Writes still asserted in later cycles of the same access are not repeated.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE → WAIT on access start when the selected wait count N > 0. wait_n = 0 in the same cycle; counter loads N-1.
  - IDLE → HOLD on access start when N = 0.
  - WAIT: wait_n = 0 while counter ≠ 0; counter decrements each cycle. On counter = 0: wait_n = 1, go to HOLD. Total wait_n-low cycles = N exactly.
  - HOLD: wait_n = 1; stay until mem_acc and io_acc both drop, then go to IDLE.
  - Back-to-back accesses need at least one strobe-inactive cycle between them.
- Backdoor:
  - bd_we writes the array selected by bd_io.
  - If bd_we and a CPU write hit the same array and address in the same cycle, the CPU write wins.
  - Backdoor writes are never logged.
- Trace FIFO:
  - Pop when log_valid & log_ready.
  - Push while full with a simultaneous pop: accepted, count unchanged.
  - Push while full with no pop: entry dropped, log_overflow set. It clears only on reset.
  - Pop while empty: ignored.
- Reset mid-access: FSM returns to IDLE, wait_n = 1, FIFO empties, and any write in the reset cycle is suppressed.

Optional Feature:
- TV80_BUS_READ_LOG_EN defined:
  - Reads are also logged, at access start, with the data currently in the array.
  - log_data widens to AW+10 as {is_rd, is_io, addr, data}.
- Not defined: writes only; log_data is AW+9 bits, and no is_rd bit exists.

Decomposition:
- Package tv80_bus_pkg holds:
  - the FSM state enum (IDLE/WAIT/HOLD);
  - the access-kind enum (MEM_RD, MEM_WR, IO_RD, IO_WR);
  - the wait-counter width constant (4);
  - the log-entry field offsets.
- Sub-module bus_log_fifo: synchronous FIFO parametrised by DEPTH and WIDTH, with push/pop/count/full/overflow.
- The top level holds the arrays, decode, FSM and backdoor.

Test Plan:
- Fetch path, MEM_WAIT=0: backdoor-load 0000:DD CB 70 78 and 9407:76; run tv80s with IX=9397 → A=42, F=55, PC=0004, R=02; no log entries.
- IO wait count: IO_WAIT=3; CPU executes OUT (5A),A with A=A5 → wait_n low exactly 3 consecutive cycles; io[5A]=A5; log head = {1, 005A, A5}.
- MEM_WAIT=2 during LD (8000),A with A=3C → each memory access shows 2 wait cycles; mem[8000]=3C; log_count=1; no duplicate entry.
- Overflow, LOG_DEPTH=4, log_ready=0: 5 CPU writes → log_count=4, log_overflow=1, entries are the first 4 writes. Then log_ready=1 for 1 cycle with a simultaneous push → count stays 4.
- Reset asserted in a WAIT cycle (IO_WAIT=5) → next cycle wait_n=1, log_valid=0; array data written earlier is still readable via bd_rdata.
- With TV80_BUS_READ_LOG_EN: LD A,(1234) where mem[1234]=9C → log entries are the opcode fetches, then {1, 0, 1234, 9C}.

Source files
------------

// File: rtl/tv80_bus_model_pkg.sv
// Shared types and constants for the tv80s bus model.
// TV80_BUS_READ_LOG_EN adds an is_rd bit on top of each trace entry.
package tv80_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} bus_state_t;

  typedef enum logic [1:0] {MEM_RD, MEM_WR, IO_RD, IO_WR} acc_kind_t;

  localparam int WAIT_CW = 4;

  localparam int LOG_DATA_LSB = 0;
  localparam int LOG_ADDR_LSB = 8;

`ifdef TV80_BUS_READ_LOG_EN
  localparam int LOG_EXTRA = 10;
`else
  localparam int LOG_EXTRA = 9;
`endif

  // Bit position of is_io, just above the address field
  function automatic int log_io_bit(input int aw);
    return aw + 8;
  endfunction

  // Bit position of is_rd, only present when read logging is enabled
  function automatic int log_rd_bit(input int aw);
    return aw + 9;
  endfunction

endpackage

// File: rtl/tv80_bus_model_if.sv
// CPU-side bus of the tv80s: address, data and strobes in, di and wait_n out.
interface tv80_bus_if #(parameter int AW = 16);
  logic [AW-1:0] a;
  logic [7:0]    cpu_do;
  logic [7:0]    di;
  logic          mreq_n;
  logic          iorq_n;
  logic          rd_n;
  logic          wr_n;
  logic          m1_n;
  logic          rfsh_n;
  logic          wait_n;

  modport master (output a, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
                  input  di, wait_n);

  modport slave  (input  a, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
                  output di, wait_n);
endinterface

// File: rtl/tv80_bus_model_bus_log_fifo.sv
// Synchronous trace FIFO; a push while full is only taken if a pop frees a slot.
module bus_log_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             r_overflow;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  assign o_data     = r_mem[r_rptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // Entry storage; when full with a pop, the new entry lands in the slot being vacated
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/tv80_bus_model.sv
// Memory and I/O target for the tv80s bus with wait-state injection,
// a backdoor port and a write-trace FIFO.
// Define TV80_BUS_READ_LOG_EN to also log reads (adds an is_rd bit).
module tv80_bus_model
  import tv80_bus_pkg::*;
#(
  parameter int AW        = 16,
  parameter int IO_AW     = 8,
  parameter int MEM_WAIT  = 0,
  parameter int IO_WAIT   = 1,
  parameter int LOG_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  tv80_bus_if.slave                  bus,
  input  logic                       bd_we,
  input  logic                       bd_io,
  input  logic [AW-1:0]              bd_addr,
  input  logic [7:0]                 bd_wdata,
  output logic [7:0]                 bd_rdata,
  output logic                       log_valid,
  input  logic                       log_ready,
  output logic [AW+LOG_EXTRA-1:0]    log_data,
  output logic [$clog2(LOG_DEPTH):0] log_count,
  output logic                       log_overflow
);
  localparam int LW     = AW + LOG_EXTRA;
  localparam int IO_BIT = log_io_bit(AW);
  localparam logic [WAIT_CW-1:0] MEM_N = WAIT_CW'(MEM_WAIT);
  localparam logic [WAIT_CW-1:0] IO_N  = WAIT_CW'(IO_WAIT);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_io  [0:(1<<IO_AW)-1];

  bus_state_t       r_state;
  logic [WAIT_CW-1:0] r_cnt;
  logic             r_wait_n;
  logic [7:0]       r_di;
  logic [7:0]       r_bd_rdata;

  logic             w_mem_acc;
  logic             w_io_acc;
  logic             w_access;
  logic             w_start;
  acc_kind_t        w_kind;
  logic             w_is_io;
  logic             w_is_wr;
  logic [WAIT_CW-1:0] w_n;
  logic [IO_AW-1:0] w_port;
  logic             w_mem_we;
  logic             w_io_we;
  logic [7:0]       w_arr_byte;
  logic             w_push;
  logic [LW-1:0]    w_log_entry;
  logic [$clog2(LOG_DEPTH):0] w_count;

  // Refresh and interrupt acknowledge cycles never count as accesses
  assign w_mem_acc = !bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n);
  assign w_io_acc  = !bus.iorq_n && bus.m1_n   && (!bus.rd_n || !bus.wr_n);
  assign w_access  = w_mem_acc || w_io_acc;
  assign w_start   = (r_state == IDLE) && w_access && !reset;

  // Classify the access so wait count, write target and log fields follow from one place
  always_comb begin
    if (w_io_acc) w_kind = bus.wr_n ? IO_RD : IO_WR;
    else          w_kind = bus.wr_n ? MEM_RD : MEM_WR;
  end

  assign w_is_io    = (w_kind == IO_RD) || (w_kind == IO_WR);
  assign w_is_wr    = (w_kind == MEM_WR) || (w_kind == IO_WR);
  assign w_n        = w_is_io ? IO_N : MEM_N;
  assign w_port     = bus.a[IO_AW-1:0];
  assign w_mem_we   = w_start && (w_kind == MEM_WR);
  assign w_io_we    = w_start && (w_kind == IO_WR);
  assign w_arr_byte = w_is_io ? r_io[w_port] : r_mem[bus.a];

`ifdef TV80_BUS_READ_LOG_EN
  assign w_push = w_start;
`else
  assign w_push = w_start && w_is_wr;
`endif

  // Assemble the trace entry from the package field offsets
  always_comb begin
    w_log_entry = '0;
    w_log_entry[LOG_DATA_LSB +: 8]  = w_is_wr ? bus.cpu_do : w_arr_byte;
    w_log_entry[LOG_ADDR_LSB +: AW] = bus.a;
    w_log_entry[IO_BIT]             = w_is_io;
`ifdef TV80_BUS_READ_LOG_EN
    w_log_entry[log_rd_bit(AW)]     = !w_is_wr;
`endif
  end

  // Memory array: backdoor first so a same-address CPU write overrides it
  always_ff @(posedge clk) begin
    if (bd_we && !bd_io) r_mem[bd_addr] <= bd_wdata;
    if (w_mem_we)        r_mem[bus.a]   <= bus.cpu_do;
  end

  // I/O array: same priority as memory, ports selected by the low address bits
  always_ff @(posedge clk) begin
    if (bd_we && bd_io) r_io[bd_addr[IO_AW-1:0]] <= bd_wdata;
    if (w_io_we)        r_io[w_port]             <= bus.cpu_do;
  end

  // Registered read data for the CPU and the backdoor, refreshed every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_di       <= '0;
      r_bd_rdata <= '0;
    end else begin
      r_di       <= !bus.iorq_n ? r_io[w_port] : r_mem[bus.a];
      r_bd_rdata <= bd_io ? r_io[bd_addr[IO_AW-1:0]] : r_mem[bd_addr];
    end
  end

  // Access FSM: holds wait_n low for exactly N cycles, then waits for strobes to drop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_wait_n <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (w_n != '0) begin
              r_state  <= WAIT;
              r_wait_n <= 1'b0;
              r_cnt    <= w_n - 1'b1;
            end else begin
              r_state  <= HOLD;
            end
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_wait_n <= 1'b1;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (!w_access) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bus_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (LW)
  ) u_log (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_data     (w_log_entry),
    .i_pop      (log_ready),
    .o_data     (log_data),
    .o_count    (w_count),
    .o_overflow (log_overflow)
  );

  assign log_count  = w_count;
  assign log_valid  = (w_count != '0);
  assign bus.di     = r_di;
  assign bus.wait_n = r_wait_n;
  assign bd_rdata   = r_bd_rdata;
endmodule

// File: tb/tb_tv80_bus_model.sv
// Self-checking bench for tv80_bus_model: the bench plays the CPU, keeps
// plain array and queue models of the memory, I/O space and trace FIFO.
module tb_tv80_bus_model;
  import tv80_bus_pkg::*;

  localparam int AW        = 16;
  localparam int IO_AW     = 8;
  localparam int MEM_WAIT  = 0;
  localparam int IO_WAIT   = 3;
  localparam int LOG_DEPTH = 4;
  localparam int LW        = AW + LOG_EXTRA;

  logic clk = 1'b0;
  logic reset;
  logic bdWe;
  logic bdIo;
  logic [AW-1:0] bdAddr;
  logic [7:0] bdWdata;
  logic [7:0] bdRdata;
  logic logValid;
  logic logReady;
  logic [LW-1:0] logData;
  logic [$clog2(LOG_DEPTH):0] logCount;
  logic logOverflow;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] memModel [0:(1<<AW)-1];
  logic [7:0] ioModel  [0:(1<<IO_AW)-1];
  logic [LW-1:0] expLog [$];
  logic expOverflow;
  logic [AW-1:0] memPool [8];
  logic [7:0] ioPool [4];

  tv80_bus_if #(.AW(AW)) busIf ();

  tv80_bus_model #(
    .AW(AW), .IO_AW(IO_AW), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (busIf),
    .bd_we        (bdWe),
    .bd_io        (bdIo),
    .bd_addr      (bdAddr),
    .bd_wdata     (bdWdata),
    .bd_rdata     (bdRdata),
    .log_valid    (logValid),
    .log_ready    (logReady),
    .log_data     (logData),
    .log_count    (logCount),
    .log_overflow (logOverflow)
  );

  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] makeEntry(input logic isIo, input logic [AW-1:0] addr,
                                              input logic [7:0] d);
`ifdef TV80_BUS_READ_LOG_EN
    return {1'b0, isIo, addr, d};
`else
    return {isIo, addr, d};
`endif
  endfunction

  task automatic modelPush(input logic [LW-1:0] e, input bit popFirst);
    if (popFirst && expLog.size() > 0) void'(expLog.pop_front());
    if (expLog.size() < LOG_DEPTH) expLog.push_back(e);
    else expOverflow = 1'b1;
  endtask

  task automatic busIdle();
    busIf.mreq_n = 1'b1;
    busIf.iorq_n = 1'b1;
    busIf.rd_n   = 1'b1;
    busIf.wr_n   = 1'b1;
    busIf.m1_n   = 1'b1;
    busIf.rfsh_n = 1'b1;
  endtask

  // One complete CPU access: start, count wait cycles, check read data, release
  task automatic applyStimulus(input bit isIo, input bit isWr, input logic [AW-1:0] addr,
                               input logic [7:0] data, input bit popAtStart, input bit collide);
    int lowCycles;
    logic [7:0] expByte;
    string kindTag;
    if (isIo) kindTag = "io"; else kindTag = "mem";
    @(negedge clk);
    busIf.a      = addr;
    busIf.cpu_do = data;
    busIf.mreq_n = isIo;
    busIf.iorq_n = !isIo;
    busIf.rd_n   = isWr;
    busIf.wr_n   = !isWr;
    logReady     = popAtStart;
    if (collide) begin
      bdWe = 1'b1; bdIo = isIo; bdAddr = addr; bdWdata = ~data;
    end
    @(posedge clk); #1;
    logReady = 1'b0;
    bdWe     = 1'b0;
    expByte = isIo ? ioModel[addr[IO_AW-1:0]] : memModel[addr];
    if (isWr) begin
      if (isIo) ioModel[addr[IO_AW-1:0]] = data;
      else      memModel[addr] = data;
      modelPush(makeEntry(isIo, addr, data), popAtStart);
    end else begin
`ifdef TV80_BUS_READ_LOG_EN
      modelPush({1'b1, isIo, addr, expByte}, popAtStart);
`else
      if (popAtStart && expLog.size() > 0) void'(expLog.pop_front());
`endif
    end
    lowCycles = 0;
    while (busIf.wait_n === 1'b0 && lowCycles < 40) begin
      lowCycles++;
      @(posedge clk); #1;
    end
    checkOutput({kindTag, "WaitCycles"}, lowCycles, isIo ? IO_WAIT : MEM_WAIT);
    if (!isWr) checkOutput({kindTag, "ReadData"}, 32'(busIf.di), 32'(expByte));
    @(negedge clk);
    busIdle();
    @(posedge clk); #1;
    checkOutput("logCount", 32'(logCount), expLog.size());
    checkOutput("logOverflow", 32'(logOverflow), 32'(expOverflow));
  endtask

  task automatic backdoorWrite(input bit isIo, input logic [AW-1:0] addr, input logic [7:0] d);
    @(negedge clk);
    bdWe = 1'b1; bdIo = isIo; bdAddr = addr; bdWdata = d;
    @(posedge clk); #1;
    bdWe = 1'b0;
    if (isIo) ioModel[addr[IO_AW-1:0]] = d;
    else      memModel[addr] = d;
  endtask

  task automatic peekCheck(input string tag, input bit isIo, input logic [AW-1:0] addr);
    @(negedge clk);
    bdIo = isIo; bdAddr = addr;
    @(posedge clk); #1;
    checkOutput(tag, 32'(bdRdata), isIo ? 32'(ioModel[addr[IO_AW-1:0]]) : 32'(memModel[addr]));
  endtask

  task automatic drainLog();
    while (expLog.size() > 0) begin
      @(negedge clk);
      checkOutput("logValid", 32'(logValid), 1);
      checkOutput("logHead", 32'(logData), 32'(expLog[0]));
      logReady = 1'b1;
      @(posedge clk); #1;
      logReady = 1'b0;
      void'(expLog.pop_front());
    end
    checkOutput("logDrained", 32'(logValid), 0);
  endtask

  initial begin
    logic [1:0] kind;
    logic [7:0] d;
    logic [AW-1:0] addr;
    reset = 1'b1;
    busIdle();
    busIf.a = '0; busIf.cpu_do = '0;
    bdWe = 1'b0; bdIo = 1'b0; bdAddr = '0; bdWdata = '0;
    logReady = 1'b0;
    expOverflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstWaitN", 32'(busIf.wait_n), 1);
    checkOutput("rstDi", 32'(busIf.di), 0);
    checkOutput("rstBdRdata", 32'(bdRdata), 0);
    checkOutput("rstLogValid", 32'(logValid), 0);
    checkOutput("rstLogCount", 32'(logCount), 0);
    checkOutput("rstOverflow", 32'(logOverflow), 0);
    @(negedge clk);
    reset = 1'b0;

    memPool[0] = 16'h0000;
    memPool[1] = 16'hFFFF;
    for (int i = 2; i < 8; i++) memPool[i] = AW'($urandom);
    for (int i = 0; i < 4; i++) ioPool[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) backdoorWrite(1'b0, memPool[i], 8'($urandom));
    for (int i = 0; i < 4; i++) backdoorWrite(1'b1, {8'h00, ioPool[i]}, 8'($urandom));
    peekCheck("preloadMem", 1'b0, memPool[1]);
    peekCheck("preloadIo", 1'b1, {8'h00, ioPool[0]});
    checkOutput("backdoorNotLogged", 32'(logCount), 0);

    // Randomized mix of memory and I/O reads and writes
    for (int n = 0; n < 30; n++) begin
      kind = 2'($urandom_range(0, 3));
      d    = 8'($urandom);
      if (kind[1]) addr = {8'($urandom), ioPool[$urandom_range(0, 3)]};
      else         addr = memPool[$urandom_range(0, 7)];
      applyStimulus(kind[1], kind[0], addr, d, 1'b0, 1'b0);
      if (expLog.size() >= 3) drainLog();
    end
    drainLog();

    // OUT (5A),A with A=A5
    applyStimulus(1'b1, 1'b1, 16'h005A, 8'hA5, 1'b0, 1'b0);
    peekCheck("ioPort5A", 1'b1, 16'h005A);
    drainLog();

    // Same-address backdoor and CPU write: the CPU data must remain
    applyStimulus(1'b0, 1'b1, memPool[2], 8'h3C, 1'b0, 1'b1);
    peekCheck("collideMem", 1'b0, memPool[2]);
    applyStimulus(1'b1, 1'b1, {8'h12, ioPool[1]}, 8'h69, 1'b0, 1'b1);
    peekCheck("collideIo", 1'b1, {8'h00, ioPool[1]});
    drainLog();

    // Fill past capacity, then push with a simultaneous pop
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, memPool[i], 8'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, memPool[5], 8'($urandom), 1'b1, 1'b0);
    drainLog();
    checkOutput("overflowSticky", 32'(logOverflow), 1);

    // Reset during a wait cycle of an I/O write
    @(negedge clk);
    busIf.a = {8'h00, ioPool[2]}; busIf.cpu_do = 8'hC3;
    busIf.iorq_n = 1'b0; busIf.wr_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midWaitLow", 32'(busIf.wait_n), 0);
    ioModel[ioPool[2]] = 8'hC3;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("resetWaitN", 32'(busIf.wait_n), 1);
    checkOutput("resetLogValid", 32'(logValid), 0);
    checkOutput("resetLogCount", 32'(logCount), 0);
    checkOutput("resetOverflow", 32'(logOverflow), 0);
    expLog.delete();
    expOverflow = 1'b0;
    @(negedge clk);
    busIdle();
    reset = 1'b0;
    peekCheck("dataSurvivesReset", 1'b1, {8'h00, ioPool[2]});

    // A write presented during reset must be suppressed
    @(negedge clk);
    reset = 1'b1;
    busIf.a = memPool[3]; busIf.cpu_do = ~memModel[memPool[3]];
    busIf.mreq_n = 1'b0; busIf.wr_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    busIdle();
    reset = 1'b0;
    peekCheck("resetWriteSuppressed", 1'b0, memPool[3]);
    checkOutput("resetWriteNotLogged", 32'(logCount), 0);

    // Interrupt acknowledge and refresh cycles are ignored
    @(negedge clk);
    busIf.a = {8'h00, ioPool[3]}; busIf.cpu_do = ~ioModel[ioPool[3]];
    busIf.iorq_n = 1'b0; busIf.m1_n = 1'b0; busIf.wr_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("intAckWaitN", 32'(busIf.wait_n), 1);
    end
    @(negedge clk);
    busIdle();
    busIf.a = memPool[4]; busIf.cpu_do = ~memModel[memPool[4]];
    busIf.mreq_n = 1'b0; busIf.rfsh_n = 1'b0; busIf.wr_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    busIdle();
    peekCheck("intAckNoWrite", 1'b1, {8'h00, ioPool[3]});
    peekCheck("refreshNoWrite", 1'b0, memPool[4]);
    checkOutput("ignoredNotLogged", 32'(logCount), 0);

    // The bus keeps working after the resets
    applyStimulus(1'b1, 1'b0, {8'h77, ioPool[2]}, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, memPool[6], 8'h5E, 1'b0, 1'b0);
    drainLog();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
